// File: rtl/controle_partida.sv
// controle_partida: game-flow FSM for ultimate tic-tac-toe.
// Settle, validation and move-timeout counters live inside.
module controle_partida #(
  parameter int NUM_JOGADORES  = 2,
  parameter int ESPERA_CICLOS  = 1000,
  parameter int VALIDA_CICLOS  = 4,
  parameter int TIMEOUT_CICLOS = 5000000,
  parameter int MODO_TIMEOUT   = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       tem_jogada,
  input  logic       macro_vencida,
  input  logic       micro_jogada,
  input  logic       fim_jogo,
  output logic       zeraR_macro,
  output logic       zeraR_micro,
  output logic       registraR_macro,
  output logic       registraR_micro,
  output logic       we_board,
  output logic       we_board_state,
  output logic       sinal_macro,
  output logic       sinal_valida_macro,
  output logic       jogar_macro,
  output logic       jogar_micro,
  output logic       zeraRAM,
  output logic       zeraEdge,
  output logic       pronto,
  output logic       timeout,
  output logic [1:0] jogador_atual,
  output logic [1:0] perdedor,
  output logic [4:0] db_estado
);

  localparam int CMAX =
    (ESPERA_CICLOS > VALIDA_CICLOS) ?
    ESPERA_CICLOS : VALIDA_CICLOS;
  localparam int CW = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] ELIM = CW'(ESPERA_CICLOS - 1);
  localparam logic [CW-1:0] VLIM = CW'(VALIDA_CICLOS - 1);
  localparam logic [31:0] TLIM =
    (TIMEOUT_CICLOS > 0) ? 32'(TIMEOUT_CICLOS - 1) : 32'd0;
  localparam bit TO_ON = (TIMEOUT_CICLOS != 0);
  localparam logic [1:0] ULT = 2'(NUM_JOGADORES - 1);

  typedef enum logic [4:0] {
    INICIAL            = 5'h00,
    PREPARACAO         = 5'h01,
    JOGA_MACRO         = 5'h02,
    REGISTRA_MACRO     = 5'h03,
    VALIDA_MACRO       = 5'h04,
    JOGA_MICRO         = 5'h05,
    REGISTRA_MICRO     = 5'h06,
    VALIDA_MICRO       = 5'h07,
    REGISTRA_JOGADA    = 5'h08,
    VERIFICA_MACRO     = 5'h09,
    REGISTRA_RESULTADO = 5'h0A,
    VERIFICA_TABULEIRO = 5'h0B,
    TROCAR_JOGADOR     = 5'h0C,
    DECIDE_MACRO       = 5'h0D,
    E_RESET            = 5'h0E,
    FIM                = 5'h0F,
    ESTOURO_TEMPO      = 5'h10
  } estado_t;

  estado_t       est;
  estado_t       nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   tcnt;
  logic          de_estouro;
  logic          espera_st;
  logic          valida_st;
  logic          jogo_st;
  logic          espera_ok;
  logic          valida_ok;
  logic          expirou;
  logic          mover;

  assign espera_st = est inside {INICIAL, JOGA_MACRO,
    JOGA_MICRO, REGISTRA_JOGADA, REGISTRA_RESULTADO};
  assign valida_st = est inside {VALIDA_MACRO,
    VALIDA_MICRO, FIM};
  assign jogo_st   = est inside {JOGA_MACRO, JOGA_MICRO};
  assign espera_ok = (cnt == ELIM);
  assign valida_ok = (cnt == VLIM);
  assign expirou   = TO_ON && jogo_st && (tcnt == TLIM);
  // a move arriving on the expiry cycle takes priority
  assign mover     = espera_ok && tem_jogada;
  assign db_estado = est;

  always_comb begin
    nxt = est;
    unique case (est)
      E_RESET: nxt = INICIAL;
      INICIAL:
        if (espera_ok && iniciar) nxt = PREPARACAO;
      PREPARACAO: nxt = JOGA_MACRO;
      JOGA_MACRO:
        if (mover) nxt = REGISTRA_MACRO;
        else if (expirou) nxt = ESTOURO_TEMPO;
      REGISTRA_MACRO: nxt = VALIDA_MACRO;
      VALIDA_MACRO:
        if (valida_ok)
          nxt = macro_vencida ? PREPARACAO : JOGA_MICRO;
      JOGA_MICRO:
        if (mover) nxt = REGISTRA_MICRO;
        else if (expirou) nxt = ESTOURO_TEMPO;
      REGISTRA_MICRO: nxt = VALIDA_MICRO;
      VALIDA_MICRO:
        if (valida_ok)
          nxt = micro_jogada ? JOGA_MICRO : REGISTRA_JOGADA;
      REGISTRA_JOGADA:
        if (espera_ok) nxt = VERIFICA_MACRO;
      VERIFICA_MACRO: nxt = REGISTRA_RESULTADO;
      REGISTRA_RESULTADO:
        if (espera_ok) nxt = VERIFICA_TABULEIRO;
      VERIFICA_TABULEIRO:
        nxt = fim_jogo ? FIM : TROCAR_JOGADOR;
      TROCAR_JOGADOR:
        nxt = de_estouro ? PREPARACAO : DECIDE_MACRO;
      DECIDE_MACRO:
        nxt = macro_vencida ? PREPARACAO : JOGA_MICRO;
      FIM:
        if (valida_ok && iniciar) nxt = INICIAL;
      ESTOURO_TEMPO:
        nxt = (MODO_TIMEOUT == 1) ? FIM : TROCAR_JOGADOR;
      default: nxt = E_RESET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      est                <= E_RESET;
      cnt                <= '0;
      tcnt               <= '0;
      de_estouro         <= 1'b0;
      jogador_atual      <= 2'd0;
      perdedor           <= 2'd0;
      timeout            <= 1'b0;
      zeraR_macro        <= 1'b0;
      zeraR_micro        <= 1'b0;
      registraR_macro    <= 1'b0;
      registraR_micro    <= 1'b0;
      we_board           <= 1'b0;
      we_board_state     <= 1'b0;
      sinal_macro        <= 1'b0;
      sinal_valida_macro <= 1'b0;
      jogar_macro        <= 1'b0;
      jogar_micro        <= 1'b0;
      zeraRAM            <= 1'b0;
      zeraEdge           <= 1'b0;
      pronto             <= 1'b0;
    end else begin
      est <= nxt;

      if (nxt != est)
        cnt <= '0;
      else if ((espera_st && !espera_ok) ||
               (valida_st && !valida_ok))
        cnt <= cnt + CW'(1);

      if (nxt != est)
        tcnt <= '0;
      else if (jogo_st && (tcnt != '1))
        tcnt <= tcnt + 32'd1;

      if (est == ESTOURO_TEMPO)
        de_estouro <= 1'b1;
      else if (est == TROCAR_JOGADOR || nxt == INICIAL)
        de_estouro <= 1'b0;

      if (nxt == INICIAL)
        jogador_atual <= 2'd0;
      else if (est == TROCAR_JOGADOR)
        jogador_atual <= (jogador_atual == ULT) ?
          2'd0 : jogador_atual + 2'd1;

      if (nxt == INICIAL) begin
        timeout  <= 1'b0;
        perdedor <= 2'd0;
      end else if (nxt == ESTOURO_TEMPO) begin
        timeout <= 1'b1;
        if (MODO_TIMEOUT == 1) perdedor <= jogador_atual;
      end

      // Moore strobes registered from the next state
      zeraR_macro     <= nxt inside {INICIAL, PREPARACAO};
      zeraR_micro     <= nxt inside {INICIAL, PREPARACAO,
                                     JOGA_MICRO};
      registraR_macro <= nxt inside {REGISTRA_MACRO,
                                     DECIDE_MACRO};
      registraR_micro <= (nxt == REGISTRA_MICRO);
      we_board        <= (nxt == REGISTRA_JOGADA);
      we_board_state  <= (nxt == REGISTRA_RESULTADO);
      sinal_macro     <= nxt inside {JOGA_MACRO,
                                     REGISTRA_MACRO};
      sinal_valida_macro <= nxt inside {REGISTRA_MACRO,
        VALIDA_MACRO, REGISTRA_RESULTADO};
      jogar_macro     <= (nxt == JOGA_MACRO);
      jogar_micro     <= (nxt == JOGA_MICRO);
      zeraRAM         <= (nxt == INICIAL);
      zeraEdge        <= (nxt == INICIAL);
      pronto          <= (nxt == FIM);
    end
  end

endmodule

// File: doc/controle_partida.md
# controle_partida

Parametrised game-flow controller for the ultimate tic-tac-toe datapath. It sequences macro-board selection, micro-cell selection, validation, board write-back and turn rotation for 2–4 players. It owns its settle, validation and move-timeout counters internally instead of taking external end-of-count inputs. It adds a per-move timeout with a selectable pass or forfeit policy.

## Interface
- NUM_JOGADORES, 2: players in rotation, 2..4; JW = 2 bits fixed.
- ESPERA_CICLOS, 1000: settle window (cycles) for input/write states, ≥1.
- VALIDA_CICLOS, 4: validation window (cycles), ≥1.
- TIMEOUT_CICLOS, 5000000: maximum cycles in a play state; 0 disables the timeout.
- MODO_TIMEOUT, 0: 0 = the turn passes on timeout; 1 = the timed-out player loses.

- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- iniciar  in  1  start / restart request (level).
- tem_jogada  in  1  a player input is present (level).
- macro_vencida  in  1  the selected macro board is already decided.
- micro_jogada  in  1  the selected micro cell is already occupied.
- fim_jogo  in  1  the global board is decided.
- zeraR_macro, zeraR_micro, registraR_macro, registraR_micro  out  1 each  selection register controls.
- we_board, we_board_state  out  1 each  RAM write enables.
- sinal_macro, sinal_valida_macro, jogar_macro, jogar_micro  out  1 each  datapath mux / indicator lines.
- zeraRAM, zeraEdge  out  1 each  clear lines, high in inicial only.
- pronto  out  1  game over.
- timeout  out  1  sticky timeout flag.
- jogador_atual  out  2  player to move.
- perdedor  out  2  player that forfeited (valid when pronto & timeout).
- db_estado  out  5  current state code.

## Operation
States and codes:
- E_reset 0E → inicial.
- inicial 00 → preparacao once the settle window has elapsed and iniciar=1.
- preparacao 01 → joga_macro.
- joga_macro 02 → registra_macro once settled and tem_jogada=1.
- registra_macro 03 → valida_macro.
- valida_macro 04 → after the validation window: preparacao if macro_vencida, else joga_micro.
- joga_micro 05 → registra_micro once settled and tem_jogada=1.
- registra_micro 06 → valida_micro.
- valida_micro 07 → after the validation window: joga_micro if micro_jogada, else registra_jogada.
- registra_jogada 08 → verifica_macro once settled.
- verifica_macro 09 → registra_resultado.
- registra_resultado 0A → verifica_tabuleiro once settled.
- verifica_tabuleiro 0B → fim if fim_jogo, else trocar_jogador.
- trocar_jogador 0C → decide_macro, or preparacao when entered from estouro_tempo.
- decide_macro 0D → preparacao if macro_vencida, else joga_micro.
- fim 0F → inicial after the validation window and iniciar=1.
- estouro_tempo 10 → fim if MODO_TIMEOUT=1, else trocar_jogador.

Timeout:
- Active in joga_macro and joga_micro when TIMEOUT_CICLOS≠0.
- After TIMEOUT_CICLOS consecutive cycles in the same play state without taking the move branch, the next state is estouro_tempo.
- If the settle window and tem_jogada coincide with expiry, the move wins.

Counters:
- One shared wait counter, cleared on every state change.
- "Settled" means the counter equals ESPERA_CICLOS−1.
- "Validation window elapsed" means the counter equals VALIDA_CICLOS−1.
- Waiting states: inicial, joga_macro, joga_micro, registra_jogada, registra_resultado, valida_macro, valida_micro, fim.
- The counter saturates and does not wrap.
- The timeout counter is separate, 32-bit, saturating, and cleared on entry to each play state.

Turn rotation:
- jogador_atual increments by 1 in trocar_jogador and wraps from NUM_JOGADORES−1 to 0.
- jogador_atual is cleared in inicial.

estouro_tempo actions:
- Sets timeout=1.
- With MODO_TIMEOUT=1, also latches perdedor=jogador_atual.
- timeout and perdedor clear in inicial.

Moore outputs (all others 0):
- zeraR_macro: inicial, preparacao.
- zeraR_micro: inicial, preparacao, joga_micro.
- registraR_macro: registra_macro, decide_macro.
- registraR_micro: registra_micro.
- sinal_macro: joga_macro, registra_macro.
- sinal_valida_macro: registra_macro, valida_macro, registra_resultado.
- we_board: registra_jogada.
- we_board_state: registra_resultado.
- jogar_macro: joga_macro.
- jogar_micro: joga_micro.
- pronto: fim.

## Timing
- Reset is sampled on the clock edge.
- After a reset edge:
  - state = E_reset, db_estado = 0x0E.
  - All strobes and pronto = 0.
  - timeout = 0, jogador_atual = 0, perdedor = 0.
  - Both counters = 0.
- Reset asserted mid-game aborts immediately at the next edge, with no RAM write completion.
- Minimum residence:
  - ESPERA_CICLOS cycles in each settle state.
  - VALIDA_CICLOS cycles in each validation state and in fim.
  - 1 cycle in every other state.
- we_board stays high for exactly ESPERA_CICLOS cycles per move.
- jogador_atual changes on the edge leaving trocar_jogador, so it is first visible in decide_macro or preparacao.
- A move with no conflicts and all windows at 1 takes 12 cycles, from joga_macro entry to the next player's joga_micro entry.

## Test plan
- Reset, then iniciar=1 with ESPERA=2, VALIDA=2 → db_estado 0E, 00, 00, 01, 02; all strobes low until preparacao.
- Full move with macro_vencida=0, micro_jogada=0, fim_jogo=0 → we_board high 2 cycles; jogador_atual goes 0→1 in decide_macro; next state is joga_micro.
- micro_jogada=1 on the first validation → returns to joga_micro with zeraR_micro=1; then micro_jogada=0 → registra_jogada.
- NUM_JOGADORES=3 over three moves → jogador_atual 0,1,2,0.
- TIMEOUT=8, MODO=0, no input in joga_micro → estouro_tempo at cycle 8, timeout=1, then trocar_jogador, then preparacao with the next player.
- TIMEOUT=8, MODO=1, player 1 idle → fim, pronto=1, perdedor=1; iniciar after 2 cycles → inicial, timeout=0.
